// File: rtl/vdp18_pack.sv
// Shared types and limits for the VDP18 VRAM arbiter.
package vdp18_pack;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PEND,
        ST_ACC,
        ST_RDW,
        ST_DONE
    } arb_state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    // Counter width able to hold max_val; a zero limit still gets one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/vdp18_sat_cnt.sv
// Saturating up-counter with synchronous clear; sat_o flags the limit.
module vdp18_sat_cnt
    import vdp18_pack::*;
#(
    parameter int max_g = 32
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int W = cnt_width(max_g);
    localparam logic [W-1:0] MAX_V = W'(max_g);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !sat_o) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign sat_o = (cnt_q == MAX_V);

endmodule

// File: rtl/vdp18_vram_arb.sv
// Arbitrates single CPU accesses into free VRAM slots, forcing a stolen
// slot once a request has waited starve_g access strobes.
module vdp18_vram_arb
    import vdp18_pack::*;
#(
    parameter int starve_g = 32,
    parameter int rd_lat_g = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clk_en_acc_i,
    input  logic        slot_cpu_i,
    input  logic [13:0] vid_a_i,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [13:0] cpu_a_i,
    input  logic [7:0]  cpu_d_i,
    output logic        cpu_ack_o,
    output logic [7:0]  cpu_rd_o,
    output logic        cpu_busy_o,
    output logic        ovr_o,
    input  logic        ovr_clr_i,
    output logic        steal_o,
    output logic [13:0] vram_a_o,
    output logic [7:0]  vram_d_o,
    output logic        vram_we_o,
    input  logic [7:0]  vram_d_i
);

    if (rd_lat_g < RD_LAT_MIN || rd_lat_g > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("vdp18_vram_arb: rd_lat_g outside legal range");
    end

    // Value of lat_q in the final RDW cycle; unused when rd_lat_g == 1.
    localparam logic [1:0] RDW_LAST = 2'(rd_lat_g - 1);

    arb_state_t  state_q;
    logic        we_q;
    logic [13:0] a_q;
    logic [7:0]  d_q;
    logic [7:0]  rd_q;
    logic        ack_q;
    logic        busy_q;
    logic        steal_q;
    logic        ovr_q;
    logic        ovr_d;
    logic [1:0]  lat_q;

    logic in_pend;
    logic starve_sat;
    logic grant;
    logic ovr_set;

    assign in_pend = (state_q == ST_PEND);
    assign grant   = in_pend & clk_en_acc_i & (slot_cpu_i | starve_sat);
    assign ovr_set = cpu_req_i & (state_q != ST_IDLE);
    assign ovr_d   = ovr_set | (ovr_q & ~ovr_clr_i);

    vdp18_sat_cnt #(
        .max_g(starve_g)
    ) u_starve_cnt (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .en_i   (in_pend & clk_en_acc_i & ~grant),
        .clr_i  (~in_pend | grant),
        .sat_o  (starve_sat)
    );

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            a_q     <= '0;
            d_q     <= '0;
            rd_q    <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            steal_q <= 1'b0;
            ovr_q   <= 1'b0;
            lat_q   <= '0;
        end else begin
            ack_q   <= 1'b0;
            steal_q <= 1'b0;
            ovr_q   <= ovr_d;
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req_i) begin
                        we_q    <= cpu_we_i;
                        a_q     <= cpu_a_i;
                        d_q     <= cpu_d_i;
                        busy_q  <= 1'b1;
                        state_q <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (grant) begin
                        steal_q <= ~slot_cpu_i;
                        state_q <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (we_q || RDW_LAST == 2'd0) begin
                        if (!we_q) begin
                            rd_q <= vram_d_i;
                        end
                        ack_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        lat_q   <= 2'd1;
                        state_q <= ST_RDW;
                    end
                end
                ST_RDW: begin
                    if (lat_q == RDW_LAST) begin
                        rd_q    <= vram_d_i;
                        ack_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        lat_q <= lat_q + 2'd1;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: the VRAM mux is decoded from state_q only, so a CPU request can
    // never reach vram_a_o / vram_we_o within the same cycle.
    assign vram_a_o  = (state_q == ST_ACC || state_q == ST_RDW) ? a_q : vid_a_i;
    assign vram_we_o = (state_q == ST_ACC) & we_q;
    assign vram_d_o  = d_q;

    assign cpu_ack_o  = ack_q;
    assign cpu_rd_o   = rd_q;
    assign cpu_busy_o = busy_q;
    assign ovr_o      = ovr_q;
    assign steal_o    = steal_q;

endmodule

// File: tb/tb_vdp18_vram_arb.sv
// Self-checking bench for vdp18_vram_arb with starve_g=4, rd_lat_g=2.
module tb_vdp18_vram_arb;

    localparam int STARVE = 4;
    localparam int LAT    = 2;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        clk_en_acc_i;
    logic        slot_cpu_i;
    logic [13:0] vid_a_i;
    logic        cpu_req_i;
    logic        cpu_we_i;
    logic [13:0] cpu_a_i;
    logic [7:0]  cpu_d_i;
    logic        cpu_ack_o;
    logic [7:0]  cpu_rd_o;
    logic        cpu_busy_o;
    logic        ovr_o;
    logic        ovr_clr_i;
    logic        steal_o;
    logic [13:0] vram_a_o;
    logic [7:0]  vram_d_o;
    logic        vram_we_o;
    logic [7:0]  vram_d_i;

    always #5 clk = ~clk;

    vdp18_vram_arb #(
        .starve_g(STARVE),
        .rd_lat_g(LAT)
    ) u_dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .clk_en_acc_i(clk_en_acc_i),
        .slot_cpu_i  (slot_cpu_i),
        .vid_a_i     (vid_a_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_a_i     (cpu_a_i),
        .cpu_d_i     (cpu_d_i),
        .cpu_ack_o   (cpu_ack_o),
        .cpu_rd_o    (cpu_rd_o),
        .cpu_busy_o  (cpu_busy_o),
        .ovr_o       (ovr_o),
        .ovr_clr_i   (ovr_clr_i),
        .steal_o     (steal_o),
        .vram_a_o    (vram_a_o),
        .vram_d_o    (vram_d_o),
        .vram_we_o   (vram_we_o),
        .vram_d_i    (vram_d_i)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_val(input logic [13:0] a);
        return (a == 14'h0800) ? 8'h3C : (a[7:0] ^ 8'h5A);
    endfunction

    // Transaction-level model: one outstanding request, timed from its grant edge.
    int          cyc = 0;
    bit          started = 0;
    bit          m_open = 0, m_gr = 0, m_we = 0, m_steal = 0, m_ovr = 0;
    int          m_waits = 0, m_gcyc = 0;
    logic [13:0] m_a = '0;
    logic [7:0]  m_d = '0, m_rd = '0;

    initial begin
        bit set_ovr;
        int k;
        forever begin
            @(posedge clk);
            k = cyc - m_gcyc;
            if (reset_i) begin
                started = 1;
                m_open = 0; m_gr = 0; m_ovr = 0; m_steal = 0;
                m_rd = '0; m_d = '0; m_a = '0; m_we = 0;
            end else begin
                set_ovr = cpu_req_i && m_open;
                m_ovr   = set_ovr || (m_ovr && !ovr_clr_i);
                if (!m_open) begin
                    if (cpu_req_i) begin
                        m_open = 1; m_gr = 0; m_waits = 0;
                        m_we = cpu_we_i; m_a = cpu_a_i; m_d = cpu_d_i;
                    end
                end else if (!m_gr) begin
                    if (clk_en_acc_i) begin
                        if (slot_cpu_i || m_waits == STARVE) begin
                            m_gr = 1; m_gcyc = cyc + 1; m_steal = !slot_cpu_i;
                        end else if (m_waits < STARVE) begin
                            m_waits++;
                        end
                    end
                end else begin
                    if (!m_we && k == LAT - 1) m_rd = vram_d_i;
                    if (k == (m_we ? 1 : LAT)) begin
                        m_open = 0; m_gr = 0;
                    end
                end
            end
            cyc++;
        end
    end

    // VRAM read data is valid only in the one cycle the latency implies.
    initial begin
        vram_d_i = 8'hEE;
        forever begin
            @(negedge clk);
            if (m_open && m_gr && !m_we && (cyc - m_gcyc) == LAT - 1)
                vram_d_i = mem_val(m_a);
            else
                vram_d_i = 8'hEE;
        end
    end

    initial begin
        int  k;
        bit  acc;
        bit  hold;
        forever begin
            @(posedge clk);
            #2;
            if (started) begin
                k    = cyc - m_gcyc;
                acc  = m_open && m_gr;
                hold = acc && k >= 0 && k <= (m_we ? 0 : LAT - 1);
                check("vram_a", 16'(vram_a_o), 16'(hold ? m_a : vid_a_i));
                check("vram_we", 16'(vram_we_o), 16'(acc && k == 0 && m_we));
                check("vram_d", 16'(vram_d_o), 16'(m_d));
                check("ack", 16'(cpu_ack_o), 16'(acc && k == (m_we ? 1 : LAT)));
                check("steal", 16'(steal_o), 16'(acc && k == 0 && m_steal));
                check("busy", 16'(cpu_busy_o), 16'(m_open));
                check("ovr", 16'(ovr_o), 16'(m_ovr));
                check("cpu_rd", 16'(cpu_rd_o), 16'(m_rd));
            end
        end
    end

    task automatic drive(input logic rst, input logic req, input logic we,
                         input logic [13:0] a, input logic [7:0] d,
                         input logic en, input logic slot, input logic clr);
        @(negedge clk);
        reset_i      = rst;
        cpu_req_i    = req;
        cpu_we_i     = we;
        cpu_a_i      = a;
        cpu_d_i      = d;
        clk_en_acc_i = en;
        slot_cpu_i   = slot;
        ovr_clr_i    = clr;
        vid_a_i      = 14'($urandom_range(0, 14'h1FFF));
    endtask

    task automatic idle();
        drive(0, 0, 0, 14'h0, 8'h0, 0, 0, 0);
    endtask

    // Counts cycles from the grant edge until ack, bounded to 8 cycles.
    task automatic wait_ack(output int lat, output int we_cyc, output int steal_cyc,
                            output logic [13:0] acc_a, output logic [7:0] acc_d);
        lat = 0; we_cyc = 0; steal_cyc = 0; acc_a = '0; acc_d = '0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (vram_we_o) begin
                we_cyc++;
                acc_a = vram_a_o;
                acc_d = vram_d_o;
            end
            if (steal_o) steal_cyc++;
            if (cpu_ack_o) begin
                lat = i;
                break;
            end
            idle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, wec, stc, found, steals, swaps, acks;
        logic [13:0] acc_a;
        logic [7:0]  acc_d;

        reset_i = 1; cpu_req_i = 0; cpu_we_i = 0; cpu_a_i = '0; cpu_d_i = '0;
        clk_en_acc_i = 0; slot_cpu_i = 0; ovr_clr_i = 0; vid_a_i = '0;

        drive(1, 0, 0, 14'h0, 8'h0, 0, 0, 0);
        drive(1, 1, 1, 14'h3333, 8'h33, 1, 1, 0);
        check("rst_busy", 16'(cpu_busy_o), 16'd0);
        check("rst_rd", 16'(cpu_rd_o), 16'h00);

        // Write into a free slot, requested on the first cycle out of reset.
        drive(0, 1, 1, 14'h1234, 8'hA5, 0, 0, 0);
        drive(0, 0, 0, 14'h0, 8'h0, 0, 1, 0);
        drive(0, 0, 0, 14'h0, 8'h0, 1, 1, 0);
        wait_ack(lat, wec, stc, acc_a, acc_d);
        check("wr_latency", 16'(lat), 16'd2);
        check("wr_we_cycles", 16'(wec), 16'd1);
        check("wr_addr", 16'(acc_a), 16'h1234);
        check("wr_data", 16'(acc_d), 16'h00A5);
        check("wr_steal", 16'(stc), 16'd0);
        idle();

        // Read with two-cycle VRAM latency.
        drive(0, 1, 0, 14'h0800, 8'h00, 0, 0, 0);
        drive(0, 0, 0, 14'h0, 8'h0, 1, 1, 0);
        wait_ack(lat, wec, stc, acc_a, acc_d);
        check("rd_latency", 16'(lat), 16'd3);
        check("rd_data", 16'(cpu_rd_o), 16'h003C);
        idle();
        idle();
        check("rd_hold", 16'(cpu_rd_o), 16'h003C);

        // Starvation: slot never free, strobes every other cycle.
        drive(0, 1, 1, 14'h3FFF, 8'h5A, 0, 0, 0);
        found = 0; steals = 0; swaps = 0;
        for (int k = 1; k <= 8; k++) begin
            drive(0, 0, 0, 14'h0, 8'h0, 1, 0, 0);
            @(posedge clk); #1;
            if (steal_o) begin
                steals++;
                if (found == 0) found = k;
            end
            if (vram_a_o != vid_a_i) swaps++;
            idle();
            @(posedge clk); #1;
            if (steal_o) steals++;
            if (vram_a_o != vid_a_i) swaps++;
        end
        check("starve_strobes", 16'(found), 16'd5);
        check("steal_pulses", 16'(steals), 16'd1);
        check("addr_swaps", 16'(swaps), 16'd1);

        // Overrun during PEND, then set and clear together during RDW.
        drive(0, 1, 0, 14'h0800, 8'h00, 0, 0, 0);
        drive(0, 1, 1, 14'h0111, 8'h77, 0, 0, 0);
        idle();
        check("ovr_set", 16'(ovr_o), 16'd1);
        drive(0, 0, 0, 14'h0, 8'h0, 1, 1, 0);
        idle();
        drive(0, 1, 1, 14'h0222, 8'h88, 0, 0, 1);
        idle();
        check("ovr_set_wins", 16'(ovr_o), 16'd1);
        check("ovr_rd_data", 16'(cpu_rd_o), 16'h003C);
        idle();
        drive(0, 0, 0, 14'h0, 8'h0, 0, 0, 1);
        idle();
        check("ovr_cleared", 16'(ovr_o), 16'd0);

        // Reset asserted while the write is in its access cycle.
        drive(0, 1, 1, 14'h0555, 8'hC3, 0, 0, 0);
        drive(0, 0, 0, 14'h0, 8'h0, 1, 1, 0);
        drive(1, 0, 0, 14'h0, 8'h0, 0, 0, 0);
        check("rst_in_acc", 16'(vram_we_o), 16'd1);
        @(posedge clk); #1;
        check("rst_we_low", 16'(vram_we_o), 16'd0);
        check("rst_busy_low", 16'(cpu_busy_o), 16'd0);
        check("rst_vram_d", 16'(vram_d_o), 16'd0);
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            idle();
            @(posedge clk); #1;
            if (cpu_ack_o) acks++;
        end
        check("rst_no_ack", 16'(acks), 16'd0);

        // Back-to-back: request in the cycle after ack is accepted.
        drive(0, 1, 1, 14'h0A0A, 8'h11, 0, 0, 0);
        drive(0, 0, 0, 14'h0, 8'h0, 1, 1, 0);
        wait_ack(lat, wec, stc, acc_a, acc_d);
        check("b2b_latency", 16'(lat), 16'd2);
        idle();
        drive(0, 1, 1, 14'h0B0B, 8'h22, 0, 0, 0);
        idle();
        check("b2b_no_ovr", 16'(ovr_o), 16'd0);
        check("b2b_busy", 16'(cpu_busy_o), 16'd1);
        drive(0, 0, 0, 14'h0, 8'h0, 1, 1, 0);
        wait_ack(lat, wec, stc, acc_a, acc_d);
        check("b2b_addr", 16'(acc_a), 16'h0B0B);

        // A request during DONE itself is an overrun.
        drive(0, 1, 1, 14'h0C0C, 8'h33, 0, 0, 0);
        idle();
        check("done_ovr", 16'(ovr_o), 16'd1);
        check("done_dropped", 16'(cpu_busy_o), 16'd0);
        idle();
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
